branch_predictor_ctrl: RTL and testbench

BRANCH_PREDICTOR_CTRL -- requirements
Module: branch_predictor_ctrl

---
 rtl/branch_predictor_ctrl.sv | 179 +++++++++++++++++
 tb/tb_branch_predictor_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_ctrl.sv
// Branch predictor table controller: one read port shared by fetch lookups and queued RMW updates.
// Optional BPC_STATS_EN adds saturating update/force-stall counters.
module branch_predictor_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef BPC_STATS_EN
  output logic [15:0] stat_upd,
  output logic [15:0] stat_force,
`endif
  input  logic        lk_valid,
  input  logic [9:0]  lk_addr,
  output logic        lk_ready,
  output logic        lk_taken,
  output logic [29:0] lk_target,
  input  logic        rs_valid,
  output logic        rs_ready,
  input  logic [9:0]  rs_addr,
  input  logic        rs_taken,
  input  logic [29:0] rs_target,
  output logic [9:0]  tb_addrr,
  output logic [9:0]  tb_addrw,
  output logic        tb_we,
  output logic        tb_next,
  output logic [29:0] tb_wdata,
  input  logic [30:0] tb_rdata
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TGT_W  = 30;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STV_W  = $clog2(STARVE_LIM + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
    logic [TGT_W-1:0]  target;
  } upd_t;

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_e;

  state_e            state_q, state_d;
  upd_t              mem_q [DEPTH];
  upd_t              mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              drain_q, drain_d;

  logic empty, full, push, update_grant;
  upd_t head;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign push         = rs_valid && !full;
  assign update_grant = !empty && (!lk_valid || (state_q == FORCE));
  assign head         = mem_q[rd_ptr_q];

  // Queue bookkeeping and starvation counter
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = starve_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: rs_addr, taken: rs_taken, target: rs_target};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (update_grant) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(update_grant);
    if (update_grant) begin
      starve_d = '0;
    end else if ((state_q == PEND) && (starve_q < STV_W'(STARVE_LIM))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      drain_q  <= drain_d;
    end
  end

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  // Next state; a FORCE entered because the queue filled keeps the port until the queue empties
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (push) state_d = PEND;
      PEND: begin
        if (count_d == '0) begin
          state_d = IDLE;
        end else if ((starve_d == STV_W'(STARVE_LIM)) || (count_d == CNT_W'(DEPTH))) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        if (count_d == '0)  state_d = IDLE;
        else if (!drain_q)  state_d = PEND;
      end
      default: state_d = IDLE;
    endcase
    drain_d = (state_d == FORCE) && (drain_q || (count_d == CNT_W'(DEPTH)));
  end

  // Table port and lookup response steering
  always_comb begin
    tb_addrr  = lk_addr;
    tb_addrw  = '0;
    tb_we     = 1'b0;
    tb_next   = 1'b0;
    tb_wdata  = '0;
    lk_taken  = 1'b0;
    lk_target = '0;
    if (update_grant) begin
      tb_addrr = head.addr;
      tb_addrw = head.addr;
      tb_we    = 1'b1;
      tb_next  = head.taken;
      tb_wdata = head.target;
    end
    lk_ready = Reset && lk_valid && !update_grant;
    if (lk_ready) begin
      lk_taken  = tb_rdata[0];
      lk_target = tb_rdata[30:1];
    end
    rs_ready = !full;
  end

`ifdef BPC_STATS_EN
  logic [15:0] stat_upd_q, stat_upd_d, stat_force_q, stat_force_d;

  always_comb begin
    stat_upd_d   = stat_upd_q;
    stat_force_d = stat_force_q;
    if (update_grant && (stat_upd_q != '1)) begin
      stat_upd_d = stat_upd_q + 16'(1);
    end
    if (update_grant && lk_valid && (state_q == FORCE) && (stat_force_q != '1)) begin
      stat_force_d = stat_force_q + 16'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stat_upd_q   <= '0;
      stat_force_q <= '0;
    end else begin
      stat_upd_q   <= stat_upd_d;
      stat_force_q <= stat_force_d;
    end
  end

  assign stat_upd   = stat_upd_q;
  assign stat_force = stat_force_q;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Scoreboard bench for branch_predictor_ctrl: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_branch_predictor_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        lk_valid = 1'b0;
  logic [9:0]  lk_addr = '0;
  logic        lk_ready, lk_taken;
  logic [29:0] lk_target;
  logic        rs_valid = 1'b0;
  logic        rs_ready;
  logic [9:0]  rs_addr = '0;
  logic        rs_taken = 1'b0;
  logic [29:0] rs_target = '0;
  logic [9:0]  tb_addrr, tb_addrw;
  logic        tb_we, tb_next;
  logic [29:0] tb_wdata;
  logic [30:0] tb_rdata;
`ifdef BPC_STATS_EN
  logic [15:0] stat_upd, stat_force;
`endif

  int checks = 0;
  int failures = 0;
  int cyc_id = 0;

  branch_predictor_ctrl #(.DEPTH(4), .STARVE_LIM(8)) dut (
    .Clk(Clk), .Reset(Reset),
`ifdef BPC_STATS_EN
    .stat_upd(stat_upd), .stat_force(stat_force),
`endif
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .lk_taken(lk_taken), .lk_target(lk_target),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_addr(rs_addr),
    .rs_taken(rs_taken), .rs_target(rs_target),
    .tb_addrr(tb_addrr), .tb_addrw(tb_addrw), .tb_we(tb_we),
    .tb_next(tb_next), .tb_wdata(tb_wdata), .tb_rdata(tb_rdata)
  );

  always #5 Clk = ~Clk;

  // Table model: entry i starts as target 0x1000+i, taken = i[0]
  logic [30:0] tbl [1024];
  logic        tbl_ready = 1'b0;
  assign tb_rdata = tbl[tb_addrr];

  always @(posedge Clk) begin
    if (!tbl_ready) begin
      for (int i = 0; i < 1024; i++) tbl[i] <= {30'h1000 + 30'(i), 1'(i)};
      tbl_ready <= 1'b1;
    end else if (tb_we) begin
      tbl[tb_addrw] <= {tb_wdata, tb_next};
    end
  end

  typedef struct {
    int          id;
    logic        lr;
    logic        lt;
    logic [29:0] ltg;
    logic        we;
    logic [9:0]  ar;
    logic [9:0]  aw;
    logic        nx;
    logic [29:0] wd;
    logic        rr;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t e_lk(input logic lr, input logic lt, input logic [29:0] ltg,
                                input logic [9:0] ar, input logic rr);
    exp_t e;
    e.id = 0; e.lr = lr; e.lt = lt; e.ltg = ltg; e.we = 1'b0;
    e.ar = ar; e.aw = '0; e.nx = 1'b0; e.wd = '0; e.rr = rr;
    return e;
  endfunction

  function automatic exp_t e_wr(input logic [9:0] a, input logic nx, input logic [29:0] wd,
                                input logic rr);
    exp_t e;
    e.id = 0; e.lr = 1'b0; e.lt = 1'b0; e.ltg = '0; e.we = 1'b1;
    e.ar = a; e.aw = a; e.nx = nx; e.wd = wd; e.rr = rr;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT should present during it
  task automatic cyc(input logic rst, input logic lv, input logic [9:0] la, input logic rv,
                     input logic [9:0] ra, input logic rtk, input logic [29:0] rtg, input exp_t e);
    exp_t x;
    @(posedge Clk);
    #1;
    Reset = rst; lk_valid = lv; lk_addr = la;
    rs_valid = rv; rs_addr = ra; rs_taken = rtk; rs_target = rtg;
    x = e;
    x.id = cyc_id;
    cyc_id++;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, id, act, req);
    end
  endtask

  // Monitor: compare every presented cycle against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("lk_ready",  e.id, 32'(lk_ready),  32'(e.lr));
        chk("lk_taken",  e.id, 32'(lk_taken),  32'(e.lt));
        chk("lk_target", e.id, 32'(lk_target), 32'(e.ltg));
        chk("tb_we",     e.id, 32'(tb_we),     32'(e.we));
        chk("tb_addrr",  e.id, 32'(tb_addrr),  32'(e.ar));
        chk("tb_addrw",  e.id, 32'(tb_addrw),  32'(e.aw));
        chk("tb_next",   e.id, 32'(tb_next),   32'(e.nx));
        chk("tb_wdata",  e.id, 32'(tb_wdata),  32'(e.wd));
        chk("rs_ready",  e.id, 32'(rs_ready),  32'(e.rr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Held in reset with a live lookup and update: nothing served, nothing queued
    cyc(0, 1, 10'd5, 1, 10'd9, 1, 30'h3, e_lk(0, 0, 30'h0, 10'd5, 1));
    cyc(0, 1, 10'd5, 0, 10'd0, 0, 30'h0, e_lk(0, 0, 30'h0, 10'd5, 1));

    // Plain lookup after reset
    cyc(1, 1, 10'd5, 0, 10'd0, 0, 30'h0, e_lk(1, 1, 30'h1005, 10'd5, 1));
    cyc(1, 0, 10'd0, 0, 10'd0, 0, 30'h0, e_lk(0, 0, 30'h0, 10'd0, 1));

    // Single update with no lookup pressure: written the cycle after the push
    cyc(1, 0, 10'd0, 1, 10'd3, 1, 30'h100, e_lk(0, 0, 30'h0, 10'd0, 1));
    cyc(1, 0, 10'd0, 0, 10'd0, 0, 30'h0, e_wr(10'd3, 1, 30'h100, 1));
    cyc(1, 1, 10'd3, 0, 10'd0, 0, 30'h0, e_lk(1, 1, 30'h100, 10'd3, 1));

    // Starvation: 8 served lookups see stale data, then FORCE steals one cycle
    cyc(1, 1, 10'd7, 1, 10'd7, 0, 30'h2AA, e_lk(1, 1, 30'h1007, 10'd7, 1));
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 10'd7, 0, 10'd0, 0, 30'h0, e_lk(1, 1, 30'h1007, 10'd7, 1));
    cyc(1, 1, 10'd7, 0, 10'd0, 0, 30'h0, e_wr(10'd7, 0, 30'h2AA, 1));
    cyc(1, 1, 10'd7, 0, 10'd0, 0, 30'h0, e_lk(1, 0, 30'h2AA, 10'd7, 1));

    // Reset with three updates queued: all discarded, no write afterwards
    cyc(1, 1, 10'd2, 1, 10'd30, 1, 30'h30, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(1, 1, 10'd2, 1, 10'd31, 1, 30'h31, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(1, 1, 10'd2, 1, 10'd32, 1, 30'h32, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(0, 1, 10'd2, 0, 10'd0, 0, 30'h0, e_lk(0, 0, 30'h0, 10'd2, 1));
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 10'd0, 0, 10'd0, 0, 30'h0, e_lk(0, 0, 30'h0, 10'd0, 1));
    cyc(1, 1, 10'd30, 0, 10'd0, 0, 30'h0, e_lk(1, 0, 30'h101E, 10'd30, 1));

    // Fill the queue under lookup pressure; full forces an in-order drain, push while full is dropped
    cyc(1, 1, 10'd2, 1, 10'd10, 1, 30'h10, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(1, 1, 10'd2, 1, 10'd11, 0, 30'h11, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(1, 1, 10'd2, 1, 10'd12, 1, 30'h12, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(1, 1, 10'd2, 1, 10'd13, 0, 30'h13, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(1, 1, 10'd2, 1, 10'd20, 1, 30'h20, e_wr(10'd10, 1, 30'h10, 0));
    cyc(1, 1, 10'd2, 0, 10'd0, 0, 30'h0, e_wr(10'd11, 0, 30'h11, 1));
    cyc(1, 1, 10'd2, 0, 10'd0, 0, 30'h0, e_wr(10'd12, 1, 30'h12, 1));
    cyc(1, 1, 10'd2, 0, 10'd0, 0, 30'h0, e_wr(10'd13, 0, 30'h13, 1));
    cyc(1, 1, 10'd2, 0, 10'd0, 0, 30'h0, e_lk(1, 0, 30'h1002, 10'd2, 1));
    cyc(1, 0, 10'd0, 0, 10'd0, 0, 30'h0, e_lk(0, 0, 30'h0, 10'd0, 1));
    cyc(1, 1, 10'd20, 0, 10'd0, 0, 30'h0, e_lk(1, 0, 30'h1014, 10'd20, 1));

`ifdef BPC_STATS_EN
    @(posedge Clk);
    #1;
    chk("stat_upd",   cyc_id, 32'(stat_upd),   32'd4);
    chk("stat_force", cyc_id, 32'(stat_force), 32'd4);
`endif

    // Simultaneous push and pop, pointers wrapping
    cyc(1, 0, 10'd0, 1, 10'd40, 1, 30'h40, e_lk(0, 0, 30'h0, 10'd0, 1));
    cyc(1, 0, 10'd0, 1, 10'd41, 0, 30'h41, e_wr(10'd40, 1, 30'h40, 1));
    cyc(1, 0, 10'd0, 1, 10'd42, 1, 30'h42, e_wr(10'd41, 0, 30'h41, 1));
    cyc(1, 0, 10'd0, 0, 10'd0, 0, 30'h0, e_wr(10'd42, 1, 30'h42, 1));
    cyc(1, 0, 10'd0, 0, 10'd0, 0, 30'h0, e_lk(0, 0, 30'h0, 10'd0, 1));
    cyc(1, 1, 10'd41, 0, 10'd0, 0, 30'h0, e_lk(1, 0, 30'h41, 10'd41, 1));

    @(posedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
